// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Bit-counter width; a one-bit counter is the minimum even for WIDTH=2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready handshake plus result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow, overflow
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two-input NANDs, with a behavioural
// twin checked against the gate network.
module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_n1, w_n2, w_n3, w_p;
  logic w_m1, w_m2, w_m3;
  logic w_nx, w_np, w_t1, w_t2;
  logic [1:0] w_beh;

  // w_p = x ^ y, then o_d = w_p ^ bin
  assign w_n1 = ~(i_x & i_y);
  assign w_n2 = ~(i_x & w_n1);
  assign w_n3 = ~(i_y & w_n1);
  assign w_p  = ~(w_n2 & w_n3);
  assign w_m1 = ~(w_p & i_bin);
  assign w_m2 = ~(w_p & w_m1);
  assign w_m3 = ~(i_bin & w_m1);
  assign o_d  = ~(w_m2 & w_m3);

  // o_bout = (~x & y) | (~(x ^ y) & bin)
  assign w_nx   = ~(i_x & i_x);
  assign w_np   = ~(w_p & w_p);
  assign w_t1   = ~(w_nx & i_y);
  assign w_t2   = ~(w_np & i_bin);
  assign o_bout = ~(w_t1 & w_t2);

  assign w_beh = {1'b0, i_x} - {1'b0, i_y} - {1'b0, i_bin};

  always_comb begin : p_equiv
    assert (w_beh == {o_bout, o_d});
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a borrow FF.
// Result, borrow and overflow are registered once at the end of RUN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic [CntW-1:0]  r_cnt;
  logic             r_bin, r_a_msb, r_b_msb;
  logic             r_ready, r_busy, r_done, r_borrow, r_ovf;
  logic             w_d, w_bout;
  logic             w_unused;

  full_subtractor u_cell (
    .i_x    (r_a[0]),
    .i_y    (r_b[0]),
    .i_bin  (r_bin),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // The last result bit comes straight from the cell, so r_res[0] is never read.
  assign w_unused = r_res[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= StRun;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bin <= w_bout;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_state  <= StDone;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.diff     = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;

  serial_subtractor_if #(.WIDTH(W)) bus_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus_if.ready), 32'h1);
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus_if.done), 32'h0);
    chk({tag, "_diff"}, 32'(bus_if.diff), 32'h0);
    chk({tag, "_borrow"}, 32'(bus_if.borrow), 32'h0);
    chk({tag, "_overflow"}, 32'(bus_if.overflow), 32'h0);
  endtask

  // Tick until done is seen; lat counts edges after the accepting edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus_if.done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    tick();
    bus_if.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] d,
                              input logic br, input logic ov);
    chk({tag, "_diff"}, 32'(bus_if.diff), 32'(d));
    chk({tag, "_borrow"}, 32'(bus_if.borrow), 32'(br));
    chk({tag, "_overflow"}, 32'(bus_if.overflow), 32'(ov));
  endtask

  initial begin
    int          lat;
    int          t_prev;
    logic [W-1:0] ra, rb;
    logic [W:0]   m;
    logic         mov;
    logic [W-1:0] held_a [3];
    logic [W-1:0] held_b [3];
    logic [W-1:0] held_d [3];

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 0x5A - 0x23
    bus_if.start = 1'b1;
    bus_if.a = 8'h5A;
    bus_if.b = 8'h23;
    tick();
    bus_if.start = 1'b0;
    chk("busy_after_accept", 32'(bus_if.busy), 32'h1);
    chk("ready_after_accept", 32'(bus_if.ready), 32'h0);
    wait_done(lat);
    chk("accept_to_done_edges", 32'(lat + 1), 32'd9);
    check_result("op_5a_23", 8'h37, 1'b0, 1'b0);
    tick();
    chk("done_one_cycle", 32'(bus_if.done), 32'h0);
    chk("ready_after_done", 32'(bus_if.ready), 32'h1);
    chk("diff_held", 32'(bus_if.diff), 32'h37);

    run_op(8'h00, 8'h01, lat);
    chk("op_00_01_done", 32'(bus_if.done), 32'h1);
    check_result("op_00_01", 8'hFF, 1'b1, 1'b0);
    tick();
    run_op(8'h80, 8'h01, lat);
    check_result("op_80_01", 8'h7F, 1'b0, 1'b1);
    tick();
    run_op(8'h7F, 8'hFF, lat);
    check_result("op_7f_ff", 8'h80, 1'b1, 1'b1);
    tick();

    // Start pulses during RUN and DONE must be ignored.
    bus_if.start = 1'b1;
    bus_if.a = 8'h10;
    bus_if.b = 8'h01;
    tick();
    bus_if.start = 1'b0;
    bus_if.a = 8'hAA;
    bus_if.b = 8'h55;
    tick();
    tick();
    bus_if.start = 1'b1;
    bus_if.a = 8'hFF;
    bus_if.b = 8'hFF;
    tick();
    bus_if.start = 1'b0;
    chk("busy_after_run_start", 32'(bus_if.busy), 32'h1);
    wait_done(lat);
    chk("ignored_run_start_lat", 32'(lat + 4), 32'd9);
    check_result("op_10_01", 8'h0F, 1'b0, 1'b0);
    bus_if.start = 1'b1;
    bus_if.a = 8'h33;
    bus_if.b = 8'h11;
    tick();
    bus_if.start = 1'b0;
    chk("done_start_ignored_ready", 32'(bus_if.ready), 32'h1);
    chk("done_start_ignored_busy", 32'(bus_if.busy), 32'h0);
    chk("done_start_ignored_diff", 32'(bus_if.diff), 32'h0F);

    // Reset mid-operation.
    run_op(8'h80, 8'h01, lat);
    check_result("pre_abort", 8'h7F, 1'b0, 1'b1);
    tick();
    bus_if.start = 1'b1;
    bus_if.a = 8'h55;
    bus_if.b = 8'h11;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    tick();
    rst = 1'b0;
    tick();
    run_op(8'h44, 8'h44, lat);
    chk("after_abort_lat", 32'(lat + 1), 32'd9);
    check_result("op_44_44", 8'h00, 1'b0, 1'b0);
    tick();

    // start held high across three operations.
    held_a[0] = 8'h20; held_b[0] = 8'h10; held_d[0] = 8'h10;
    held_a[1] = 8'h01; held_b[1] = 8'h02; held_d[1] = 8'hFF;
    held_a[2] = 8'hC0; held_b[2] = 8'h40; held_d[2] = 8'h80;
    bus_if.start = 1'b1;
    bus_if.a = held_a[0];
    bus_if.b = held_b[0];
    tick();
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done(lat);
      chk("held_done_seen", 32'(bus_if.done), 32'h1);
      chk("held_diff", 32'(bus_if.diff), 32'(held_d[k]));
      if (k > 0) chk("held_spacing", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
      if (k < 2) begin
        bus_if.a = held_a[k+1];
        bus_if.b = held_b[k+1];
        tick();
        tick();
      end
    end
    bus_if.start = 1'b0;
    tick();
    tick();

    // Random sweep against a 9-bit arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      m = {1'b0, ra} - {1'b0, rb};
      mov = (ra[W-1] != rb[W-1]) && (m[W-1] != ra[W-1]);
      run_op(ra, rb, lat);
      chk("rand_borrow_diff", 32'({bus_if.borrow, bus_if.diff}), 32'(m));
      chk("rand_overflow", 32'(bus_if.overflow), 32'(mov));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes `a - b` LSB-first through one full-subtractor cell and a borrow flip-flop. It uses `WIDTH` clock cycles per operation. It is the inverse-operation counterpart of the ripple full-adder datapath and serves ALU paths where area is traded for latency. Operands load on a start/ready handshake. The result, unsigned borrow and signed overflow are held stable after a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 16, operand and result width in bits (≥2).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in RUN only.
- `done`  out  1  one-cycle pulse in DONE state.
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH; held until the next accepted start.
- `borrow`  out  1  final borrow, equal to 1 iff `a < b` unsigned.
- `overflow`  out  1  signed overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- Reset values: state=IDLE, `ready`=1, `busy`=0, `done`=0, `diff`=0, `borrow`=0, `overflow`=0, bit counter=0, borrow FF=0.
- State machine:
  - IDLE --(start)--> RUN: on this edge, load `a`→A shift register and `b`→B shift register; clear borrow FF, counter and result register.
  - RUN: each edge does the following:
    - Cell computes `d = A[0]^B[0]^bin` and `bout = (~A[0]&B[0]) | (~(A[0]^B[0])&bin)`.
    - Shift `d` into the result MSB (right shift), shift A and B right, `bin←bout`, counter+1.
    - On the edge where the counter reaches WIDTH-1 (the last bit), go to DONE.
  - DONE: `done`=1 for exactly one cycle. Then go to IDLE unconditionally.
- `diff` output register updates once, on the RUN→DONE edge. The same edge captures `borrow` from the final `bout` and `overflow` from the operand MSBs (latched at load) and the final `d`.
- `start` in RUN or DONE is ignored. It is not queued.
- `start` held high continuously: the next operation is accepted on the first IDLE edge after DONE.
- Changes on `a`/`b` outside the accepting edge have no effect.
- `rst` mid-operation aborts immediately. All outputs return to reset values, and any partial result is discarded.
- Arithmetic is modulo 2^WIDTH. No sign extension; signedness is expressed only by `overflow`.

## Timing
- Accepting edge E0 (IDLE, `start`=1).
- Bits processed on edges E1..E_WIDTH.
- `done`, `diff`, `borrow` and `overflow` are valid in the cycle after E_WIDTH.
- `ready` returns to 1 after E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. Accept to `done` = WIDTH+1 edges.
- `ready`, `busy` and `done` are registered state decodes, mutually exclusive, and exactly one is high at any time.
- Outputs are glitch-free registers. There is no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding typedef (IDLE, RUN, DONE) and a counter-width function (`$clog2(WIDTH)`).
- One sub-module: `full_subtractor` (combinational; inputs x, y, bin; outputs d, bout), gate-level NAND-realisable, with a behavioural twin for equivalence checking.
- Top level holds the FSM, shift registers, counter, borrow FF and output registers.

## Test plan
All scenarios use WIDTH=8.
- 0x5A − 0x23 → `diff`=0x37, `borrow`=0, `overflow`=0; `done` exactly 9 edges after the accept.
- 0x00 − 0x01 → `diff`=0xFF, `borrow`=1, `overflow`=0.
- 0x80 − 0x01 → `diff`=0x7F, `borrow`=0, `overflow`=1. Then 0x7F − 0xFF → `diff`=0x80, `borrow`=1, `overflow`=1.
- Start accepted with 0x10 − 0x01; pulse `start` with other operands at E3 and in DONE → ignored; result 0x0F.
- Assert `rst` at E4 → all outputs return to reset values within the same cycle. Then a fresh 0x44 − 0x44 → `diff`=0x00, `borrow`=0.
- `start` held high for three operations → each accepted on the IDLE edge, 10-cycle spacing. Random 1000-vector sweep matches the `{borrow, diff}` model `a - b`.
